// File: rtl/conv_pkg.sv
// Shared types and helpers for the sequential 2-D convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, MAC, EMIT, FIN} state_t;

  // Upper bounds for the generic element extractor; flattened buses must fit BUS_MAX.
  localparam int unsigned BUS_MAX = 2048;
  localparam int unsigned EL_MAX  = 32;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned kn);
    return 2 * dw + $clog2(kn * kn);
  endfunction

  function automatic logic [EL_MAX-1:0] elem_get(input logic [BUS_MAX-1:0] bus,
                                                 input int unsigned       idx,
                                                 input int unsigned       dw);
    logic [BUS_MAX-1:0] sh;
    logic [EL_MAX-1:0]  mask;
    sh   = bus >> (idx * dw);
    mask = (dw >= EL_MAX) ? '1 : ((EL_MAX'(1) << dw) - EL_MAX'(1));
    return sh[EL_MAX-1:0] & mask;
  endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Unsigned multiply-accumulate register with synchronous clear and enable.
module conv_mac_unit #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  acc_next
);

  logic [2*DATA_W-1:0] prod;

  assign prod     = (2*DATA_W)'(a) * (2*DATA_W)'(b);
  assign acc_next = acc + ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/conv2d_seq_engine.sv
// Sequential valid-window 2-D convolution: one MAC per tap per cycle,
// raster-order results over a valid/ready handshake.
module conv2d_seq_engine
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_N  = 4,
  parameter int unsigned K_N    = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic                                   mode_sat,
  input  logic [IMG_N*IMG_N*DATA_W-1:0]          img,
  input  logic [K_N*K_N*DATA_W-1:0]              kern,
  output logic [DATA_W-1:0]                      out_data,
  output logic [idx_width(IMG_N-K_N+1)-1:0]      out_row,
  output logic [idx_width(IMG_N-K_N+1)-1:0]      out_col,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   busy,
  output logic                                   done
);

  localparam int unsigned OUT_N = IMG_N - K_N + 1;
  localparam int unsigned ACC_W = acc_width(DATA_W, K_N);
  localparam int unsigned NTAP  = K_N * K_N;
  localparam int unsigned RW    = idx_width(OUT_N);
  localparam int unsigned KW    = idx_width(K_N);
  localparam int unsigned TW    = idx_width(NTAP);
  localparam logic [DATA_W-1:0] MAX_OUT = '1;

  state_t                        state_q;
  logic [IMG_N*IMG_N*DATA_W-1:0] img_r;
  logic [K_N*K_N*DATA_W-1:0]     kern_r;
  logic                          mode_r;
  logic [RW-1:0]                 row_q;
  logic [RW-1:0]                 col_q;
  logic [KW-1:0]                 kr_q;
  logic [KW-1:0]                 kc_q;
  logic [TW-1:0]                 tap_q;

  logic                          kill;
  logic                          hs;
  logic                          last_tap;
  logic                          last_col;
  logic                          last_row;
  logic                          mac_clr;
  logic                          mac_en;
  int unsigned                   img_idx;
  logic [DATA_W-1:0]             img_el;
  logic [DATA_W-1:0]             kern_el;
  logic [ACC_W-1:0]              acc;
  logic [ACC_W-1:0]              acc_next;
  logic [DATA_W-1:0]             conv_data;

  assign out_row  = row_q;
  assign out_col  = col_q;

  assign kill     = abort && (state_q != IDLE);
  assign hs       = (state_q == EMIT) && out_ready;
  assign last_tap = (tap_q == TW'(NTAP - 1));
  assign last_col = (col_q == RW'(OUT_N - 1));
  assign last_row = (row_q == RW'(OUT_N - 1));
  assign mac_clr  = kill || ((state_q == IDLE) && start) || hs;
  assign mac_en   = (state_q == MAC);

  always_comb begin
    img_idx = (32'(row_q) + 32'(kr_q)) * IMG_N + 32'(col_q) + 32'(kc_q);
    img_el  = DATA_W'(elem_get(BUS_MAX'(img_r), img_idx, DATA_W));
    kern_el = DATA_W'(elem_get(BUS_MAX'(kern_r), 32'(tap_q), DATA_W));
  end

  // Conversion looks at acc_next so the EMIT-entry edge captures the sum including the final tap.
  always_comb begin
    conv_data = acc_next[DATA_W-1:0];
    if (mode_r && (acc_next > ACC_W'(MAX_OUT))) begin
      conv_data = MAX_OUT;
    end
  end

  conv_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clr      (mac_clr),
    .en       (mac_en),
    .a        (img_el),
    .b        (kern_el),
    .acc      (acc),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      img_r     <= '0;
      kern_r    <= '0;
      mode_r    <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      kr_q      <= '0;
      kc_q      <= '0;
      tap_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (kill) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      kr_q      <= '0;
      kc_q      <= '0;
      tap_q     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            img_r   <= img;
            kern_r  <= kern;
            mode_r  <= mode_sat;
            row_q   <= '0;
            col_q   <= '0;
            kr_q    <= '0;
            kc_q    <= '0;
            tap_q   <= '0;
            busy    <= 1'b1;
            state_q <= MAC;
          end
        end
        MAC: begin
          if (last_tap) begin
            tap_q     <= '0;
            kr_q      <= '0;
            kc_q      <= '0;
            out_data  <= conv_data;
            out_valid <= 1'b1;
            state_q   <= EMIT;
          end else begin
            tap_q <= tap_q + TW'(1);
            if (kc_q == KW'(K_N - 1)) begin
              kc_q <= '0;
              kr_q <= kr_q + KW'(1);
            end else begin
              kc_q <= kc_q + KW'(1);
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_col) begin
              col_q <= '0;
              if (last_row) begin
                row_q   <= '0;
                done    <= 1'b1;
                state_q <= FIN;
              end else begin
                row_q   <= row_q + RW'(1);
                state_q <= MAC;
              end
            end else begin
              col_q   <= col_q + RW'(1);
              state_q <= MAC;
            end
          end
        end
        FIN: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_seq_engine.sv
// Directed, table-driven bench for conv2d_seq_engine (default 4x4/3x3 plus a 5x5/2x2 instance).
module tb_conv2d_seq_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, abort, mode_sat, out_ready;
  logic [127:0] img;
  logic [71:0]  kern;
  logic [7:0]   out_data;
  logic [0:0]   out_row, out_col;
  logic         out_valid, busy, done;

  logic         start5, mode5, ready5, abort5;
  logic [199:0] img5;
  logic [31:0]  kern5;
  logic [7:0]   data5;
  logic [1:0]   row5, col5;
  logic         valid5, busy5, done5;

  conv2d_seq_engine dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode_sat(mode_sat),
    .img(img), .kern(kern), .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  conv2d_seq_engine #(.DATA_W(8), .IMG_N(5), .K_N(2)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .abort(abort5), .mode_sat(mode5),
    .img(img5), .kern(kern5), .out_data(data5), .out_row(row5), .out_col(col5),
    .out_valid(valid5), .out_ready(ready5), .busy(busy5), .done(done5)
  );

  typedef struct {
    logic [127:0]    img;
    logic [71:0]     kern;
    logic            sat;
    int unsigned     hold;
    int unsigned     disturb;
    logic [3:0][7:0] exp;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  int s1_i[16] = '{1, 2, 3, 4, 2, 3, 4, 5, 3, 4, 5, 5, 3, 4, 5, 5};
  int s1_k[9]  = '{9, 8, 7, 8, 7, 6, 7, 6, 5};

  logic [127:0] s1_img;
  logic [71:0]  s1_kern;
  vec_t         tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic [127:0] i, input logic [71:0] k, input logic s,
                               input int unsigned h, input int unsigned d,
                               input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
    vec_t v;
    v.img = i; v.kern = k; v.sat = s; v.hold = h; v.disturb = d;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  task automatic run_frame(input vec_t v, input int id);
    int unsigned cyc, nout, stall;
    bit got_done;
    nout = 0; stall = 0; got_done = 0;
    @(negedge clk);
    img = v.img; kern = v.kern; mode_sat = v.sat; out_ready = (v.hold == 0); start = 1'b1;
    @(posedge clk); #1;
    cyc = 1; start = 1'b0;
    check($sformatf("v%0d_busy_after_start", id), 32'(busy), 32'd1);
    while (!got_done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (v.disturb != 0 && cyc == v.disturb) begin
        start    = 1'b1;
        img      = ~img;
        kern     = 72'({$urandom, $urandom, $urandom});
        mode_sat = ~mode_sat;
      end else begin
        start = 1'b0;
      end
      if (out_valid) begin
        if (nout >= 4) begin
          check($sformatf("v%0d_extra_output", id), nout, 32'd3);
        end else begin
          if (stall == 0)
            check($sformatf("v%0d_valid_cycle%0d", id, nout), cyc, 10 + nout * (10 + v.hold));
          check($sformatf("v%0d_data%0d", id, nout), 32'(out_data), 32'(v.exp[nout]));
          check($sformatf("v%0d_row%0d", id, nout), 32'(out_row), nout / 2);
          check($sformatf("v%0d_col%0d", id, nout), 32'(out_col), nout % 2);
          if (stall < v.hold) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
            stall = 0;
            nout++;
          end
        end
      end
      if (done) begin
        got_done = 1;
        check($sformatf("v%0d_done_cycle", id), cyc, 41 + 4 * v.hold);
        check($sformatf("v%0d_outputs", id), nout, 32'd4);
      end
    end
    if (!got_done) check($sformatf("v%0d_done_timeout", id), 32'd0, 32'd1);
    @(posedge clk); #1;
    check($sformatf("v%0d_done_pulse_end", id), 32'(done), 32'd0);
    check($sformatf("v%0d_idle_busy", id), 32'(busy), 32'd0);
  endtask

  initial begin
    int unsigned cyc, nv, k;
    bit prev, seen, got;

    rst = 1'b1; start = 1'b0; abort = 1'b0; mode_sat = 1'b0; out_ready = 1'b1;
    img = '0; kern = '0;
    start5 = 1'b0; abort5 = 1'b0; mode5 = 1'b0; ready5 = 1'b1; img5 = '0; kern5 = '0;

    for (int i = 0; i < 16; i++) s1_img[i*8 +: 8] = 8'(s1_i[i]);
    for (int i = 0; i < 9; i++)  s1_kern[i*8 +: 8] = 8'(s1_k[i]);

    tbl[0] = mkv(s1_img, s1_kern, 1'b0, 0, 0,  8'd177, 8'd235, 8'd222, 8'd18);
    tbl[1] = mkv(s1_img, s1_kern, 1'b1, 0, 0,  8'd177, 8'd235, 8'd222, 8'd255);
    tbl[2] = mkv(s1_img, s1_kern, 1'b0, 7, 0,  8'd177, 8'd235, 8'd222, 8'd18);
    tbl[3] = mkv(s1_img, s1_kern, 1'b0, 0, 13, 8'd177, 8'd235, 8'd222, 8'd18);
    tbl[4] = mkv('1, '1, 1'b0, 2, 0, 8'd9, 8'd9, 8'd9, 8'd9);
    tbl[5] = mkv('1, '1, 1'b1, 0, 0, 8'd255, 8'd255, 8'd255, 8'd255);

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_out_row", 32'(out_row), 0);
    check("rst_out_col", 32'(out_col), 0);
    check("rst5_valid", 32'(valid5), 0);
    check("rst5_busy", 32'(busy5), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_frame(tbl[i], i);

    // Abort while the second result is stalled, coinciding with ready.
    @(negedge clk);
    img = s1_img; kern = s1_kern; mode_sat = 1'b0; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; nv = 0; prev = 0; cyc = 0;
    while (nv < 2 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid && !prev) nv++;
      prev = out_valid;
    end
    check("abort_reach_emit2", nv, 2);
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_held_valid", 32'(out_valid), 1);
    check("abort_held_data", 32'(out_data), 235);
    abort = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_valid", 32'(out_valid), 0);
    check("abort_done", 32'(done), 0);
    seen = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done || out_valid || busy) seen = 1;
    end
    check("abort_stays_idle", 32'(seen), 0);
    run_frame(tbl[0], 10);

    // Reset mid-MAC of window (0,1), with start held high.
    @(negedge clk);
    img = s1_img; kern = s1_kern; mode_sat = 1'b0; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check("rst_mid_pre_data", 32'(out_data), 177);
    check("rst_mid_pre_busy", 32'(busy), 1);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_data", 32'(out_data), 0);
    check("rst_mid_valid", 32'(out_valid), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_done", 32'(done), 0);
    check("rst_mid_row", 32'(out_row), 0);
    check("rst_mid_col", 32'(out_col), 0);
    check("rst_mid_state", 32'(dut.state_q), 0);
    rst = 1'b0; start = 1'b0;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (busy || out_valid) seen = 1;
    end
    check("rst_mid_stays_idle", 32'(seen), 0);

    // 5x5 image, 2x2 kernel, all ones: 16 results of 4, 5 cycles apart.
    @(negedge clk);
    for (int i = 0; i < 25; i++) img5[i*8 +: 8] = 8'd1;
    for (int i = 0; i < 4; i++)  kern5[i*8 +: 8] = 8'd1;
    mode5 = 1'b1; ready5 = 1'b1; start5 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0; cyc = 1; k = 0; got = 0;
    while (!got && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (valid5) begin
        check($sformatf("sw_cycle%0d", k), cyc, 5 + 5 * k);
        check($sformatf("sw_data%0d", k), 32'(data5), 4);
        check($sformatf("sw_row%0d", k), 32'(row5), k / 4);
        check($sformatf("sw_col%0d", k), 32'(col5), k % 4);
        k++;
      end
      if (done5) begin
        got = 1;
        check("sw_done_cycle", cyc, 81);
        check("sw_outputs", k, 16);
      end
    end
    if (!got) check("sw_done_timeout", 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv2d_seq_engine.md
Name: conv2d_seq_engine

Overview:
Parametrised successor to the current 4x4-image / 3x3-kernel convolution datapath. It walks every valid kernel window itself, so the bench or host no longer drives per-tap select codes. It snapshots an IMG_N x IMG_N image and a K_N x K_N kernel, then runs one multiply-accumulate per tap per cycle. Results stream out in raster order over a valid/ready handshake, with selectable saturate or truncate output mode. It sits between the operand register file and the result collector.

Parameters:
DATA_W, 8, width of unsigned image, kernel and output elements
IMG_N, 4, image side length; must be >= K_N
K_N, 3, kernel side length; must be >= 1
OUT_N, IMG_N-K_N+1 (derived, localparam), output side length
ACC_W, 2*DATA_W+$clog2(K_N*K_N) (derived, localparam), accumulator width

Ports:
clk  in  1  sole clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a frame; sampled only in IDLE
abort  in  1  synchronous cancel; return to IDLE, no done pulse
mode_sat  in  1  1 = saturate result to 2^DATA_W-1; 0 = keep low DATA_W bits; latched at start
img  in  IMG_N*IMG_N*DATA_W  flattened image; element (i,j) at bits [(i*IMG_N+j)*DATA_W +: DATA_W]; (0,0) at LSB
kern  in  K_N*K_N*DATA_W  flattened kernel; same packing with K_N
out_data  out  DATA_W  converted window sum
out_row  out  $clog2(OUT_N) min 1  output row index
out_col  out  $clog2(OUT_N) min 1  output column index
out_valid  out  1  out_data, out_row and out_col are valid
out_ready  in  1  consumer accepts when out_valid && out_ready
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last output handshake

Behaviour:
- Reset: state=IDLE; acc, tap, row and col counters =0; out_data=0; out_row=out_col=0; out_valid=0; busy=0; done=0. rst has priority over abort and start, in any state.
- States: IDLE, MAC, EMIT, FIN.
- IDLE + start: latch img, kern and mode_sat into internal registers. Clear acc, row=col=tap=0. Go to MAC. Input changes after this edge have no effect until the next frame.
- MAC: on each cycle, acc += img_r[(row+kr)*IMG_N+(col+kc)] * kern_r[kr*K_N+kc], where tap = kr*K_N+kc runs 0..K_N*K_N-1, kr-major. Arithmetic is unsigned, with no overflow inside ACC_W. After the tap K_N*K_N-1 accumulation, go to EMIT. The EMIT-entry edge registers out_data = conversion(final acc) and sets out_valid=1.
- Conversion: with mode_sat, out_data = (acc > 2^DATA_W-1) ? all-ones : acc[DATA_W-1:0]. Without mode_sat, out_data = acc[DATA_W-1:0].
- EMIT: out_valid, out_data, out_row and out_col stay stable until the handshake. Stalls are unbounded.
- On handshake in EMIT, the same edge clears out_valid. If this is not the last window: advance col; on wrap to 0, advance row; clear acc and tap; go to MAC. If it is the last window (row=col=OUT_N-1): go to FIN.
- FIN: done=1 for exactly one cycle, then IDLE with busy=0.
- Latency with out_ready tied high: first out_valid in the (K_N*K_N+1)th cycle after the start edge. Each window then takes K_N*K_N+1 cycles. Frame length is OUT_N^2*(K_N*K_N+1) cycles plus 1 FIN cycle. Default frame = 41 cycles.
- start while busy is ignored; the frame in flight is unaffected.
- abort in any non-IDLE state goes to IDLE on the next edge: out_valid=0, no done pulse, counters cleared. If abort and a handshake coincide, abort wins and the output is considered not delivered.
- K_N=IMG_N gives a single window (OUT_N=1). K_N=1 gives 1 MAC cycle per output.

Decomposition:
- Shared package conv_pkg:
  - state enum {IDLE, MAC, EMIT, FIN}
  - width helper functions for ACC_W and the index widths
  - element-extract function for the flattened buses
- One natural sub-module: conv_mac_unit (DATA_W, ACC_W), with a clear/enable multiply-accumulate register. The FSM, counters and conversion stay in the top level.

Test Plan:
1. Defaults, mode_sat=0, out_ready=1. img rows {1,2,3,4},{2,3,4,5},{3,4,5,5},{3,4,5,5}; kern rows {9,8,7},{8,7,6},{7,6,5}; pulse start. Required outputs: (0,0)=177, (0,1)=235, (1,0)=222, (1,1)=18 (274 truncated). out_valid at cycles 10,20,30,40; done at cycle 41.
2. Same frame with mode_sat=1: (1,1)=255; other three outputs unchanged.
3. Backpressure: hold out_ready=0 for 7 cycles at each EMIT. Required: out_valid and data held stable throughout; same four values in order; done at cycle 41+4*7.
4. Pulse start during MAC of window (0,1), and change img/kern mid-frame. Required: results identical to scenario 1.
5. Assert abort during the second EMIT. Required: next cycle busy=0, out_valid=0, no done pulse. A fresh start then reproduces scenario 1.
6. Assert rst mid-MAC together with start. Required: all outputs at reset values the next cycle, state IDLE. Parameter sweep IMG_N=5, K_N=2, all-ones image and kernel: 16 outputs of 4, 5 cycles each.
